// File: rtl/ucode_sequencer.sv
// Microcode sequencer: steps external state-ROM words, dispatches on fetched opcodes,
// resolves branches and arbitrates reset/NMI/IRQ entry. Optional jam halt via UCODE_HALT_EN.
//
// entry state        | meaning
// -------------------+--------------------------------------------
// RESET_STATE        | first word after reset (int_kind 11)
// NMI_STATE          | NMI sequence entry (int_kind 10)
// IRQ_STATE          | IRQ sequence entry (int_kind 01)
// FETCH_STATE        | opcode fetch after a normal last cycle (sync)
module ucode_sequencer #(
   parameter int STATE_W                = 8,
   parameter int CTRL_W                 = 23,
   parameter int OP_W                   = 14,
   parameter int FETCH_STATE            = 0,
   parameter int BRANCH_TAKEN_STATE     = 60,
   parameter int BRANCH_NOT_TAKEN_STATE = 0,
   parameter int RESET_STATE            = 62,
   parameter int NMI_STATE              = 63,
   parameter int IRQ_STATE              = 64,
   parameter int IRQ_MASK_BIT           = 2
) (
   input  logic                             ph2,
   input  logic                             reset,
   input  logic                             rdy,
   input  logic [7:0]                       data_in,
   input  logic [7:0]                       p,
   input  logic                             irq,
   input  logic                             nmi,
   output logic [STATE_W-1:0]               state,
   input  logic [CTRL_W+OP_W+STATE_W+3:0]   ucode_in,
   output logic [7:0]                       opcode,
   input  logic [OP_W+8+STATE_W:0]          op_word,
   output logic [CTRL_W+OP_W-1:0]           controls,
   output logic [7:0]                       op_flags,
   output logic                             sync,
   output logic                             int_ack,
   output logic [1:0]                       int_kind,
   output logic                             halted
);

   typedef enum logic [1:0] {
      KIND_NONE  = 2'b00,
      KIND_IRQ   = 2'b01,
      KIND_NMI   = 2'b10,
      KIND_RESET = 2'b11
   } kind_t;

   logic [STATE_W-1:0] next_state_f;
   logic [1:0]         next_sel;
   logic               op_sel;
   logic               last_cycle;
   logic [OP_W-1:0]    c_op_state;
   logic [CTRL_W-1:0]  c_state;
   logic [STATE_W-1:0] dispatch_state;
   logic               branch_polarity;
   logic [OP_W-1:0]    c_op_opcode;

   assign next_state_f    = ucode_in[STATE_W-1:0];
   assign next_sel        = ucode_in[STATE_W+1:STATE_W];
   assign op_sel          = ucode_in[STATE_W+2];
   assign last_cycle      = ucode_in[STATE_W+3];
   assign c_op_state      = ucode_in[STATE_W+4 +: OP_W];
   assign c_state         = ucode_in[STATE_W+4+OP_W +: CTRL_W];

   assign dispatch_state  = op_word[STATE_W-1:0];
   assign op_flags        = op_word[STATE_W +: 8];
   assign branch_polarity = op_word[STATE_W+8];
   assign c_op_opcode     = op_word[STATE_W+9 +: OP_W];

   logic [7:0]         opcode_q, opcode_q_nxt;
   logic [STATE_W-1:0] state_nxt, seq_target;
   logic               sync_nxt, ack_nxt;
   kind_t              kind_q, kind_nxt;
   logic               nmi_prev, nmi_pending, pending_nxt;
   logic               nmi_take, taken, boundary;
   logic               halt_q;

   assign opcode   = sync ? data_in : opcode_q;
   assign int_kind = kind_q;
   assign controls = halt_q ? '0 : {c_state, (op_sel ? c_op_opcode : c_op_state)};

`ifdef UCODE_HALT_EN
   logic halt_nxt;
   always_ff @(posedge ph2) begin
      if (reset) halt_q <= 1'b0;
      else       halt_q <= halt_nxt;
   end
   assign halted = halt_q;
`else
   assign halt_q = 1'b0;
   assign halted = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      sync_nxt     = sync;
      kind_nxt     = kind_q;
      ack_nxt      = int_ack;
      opcode_q_nxt = opcode_q;
      nmi_take     = 1'b0;
`ifdef UCODE_HALT_EN
      halt_nxt     = halt_q;
`endif
      taken = branch_polarity ^ (|(op_flags & p));
      case (next_sel)
         2'b00:   seq_target = next_state_f;
         2'b01:   seq_target = dispatch_state;
         2'b10:   seq_target = taken ? STATE_W'(BRANCH_TAKEN_STATE) : STATE_W'(BRANCH_NOT_TAKEN_STATE);
         default: seq_target = STATE_W'(FETCH_STATE);
      endcase
      // next_sel=11 returns to fetch, so it is a sequence boundary like last_cycle
      boundary = last_cycle | (next_sel == 2'b11);

      if (rdy && !halt_q) begin
         if (sync) opcode_q_nxt = data_in;
         sync_nxt = 1'b0;
         ack_nxt  = 1'b0;
`ifdef UCODE_HALT_EN
         if (next_sel == 2'b11) begin
            halt_nxt     = 1'b1;
            sync_nxt     = sync;
            opcode_q_nxt = opcode_q;
         end else
`endif
         if (boundary) begin
            if (nmi_pending) begin
               state_nxt = STATE_W'(NMI_STATE);
               kind_nxt  = KIND_NMI;
               ack_nxt   = 1'b1;
               nmi_take  = 1'b1;
            end else if (irq && !p[IRQ_MASK_BIT]) begin
               state_nxt = STATE_W'(IRQ_STATE);
               kind_nxt  = KIND_IRQ;
               ack_nxt   = 1'b1;
            end else begin
               state_nxt = seq_target;
               sync_nxt  = 1'b1;
               kind_nxt  = KIND_NONE;
            end
         end else begin
            state_nxt = seq_target;
         end
      end

      // a fresh edge wins over consuming the previous one
      pending_nxt = (nmi & ~nmi_prev) | (nmi_pending & ~nmi_take);
   end

   always_ff @(posedge ph2) begin
      if (reset) begin
         state       <= STATE_W'(RESET_STATE);
         opcode_q    <= '0;
         sync        <= 1'b0;
         nmi_pending <= 1'b0;
         nmi_prev    <= 1'b0;
         kind_q      <= KIND_RESET;
         int_ack     <= 1'b1;
      end else begin
         state       <= state_nxt;
         opcode_q    <= opcode_q_nxt;
         sync        <= sync_nxt;
         nmi_pending <= pending_nxt;
         nmi_prev    <= nmi;
         kind_q      <= kind_nxt;
         int_ack     <= ack_nxt;
      end
   end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: small state/opcode ROMs, expectations queued per cycle
// and checked by an independent negedge monitor.
module tb_ucode_sequencer;

   logic        ph2 = 1'b0;
   logic        reset, rdy, irq, nmi;
   logic [7:0]  data_in, p;
   logic [7:0]  state;
   logic [48:0] ucode_in;
   logic [7:0]  opcode;
   logic [30:0] op_word;
   logic [36:0] controls;
   logic [7:0]  op_flags;
   logic        sync, int_ack, halted;
   logic [1:0]  int_kind;

   logic [48:0] urom [0:255];
   logic [30:0] orom [0:255];

   assign ucode_in = urom[state];
   assign op_word  = orom[opcode];

   always #5 ph2 = ~ph2;

   ucode_sequencer dut (
      .ph2(ph2), .reset(reset), .rdy(rdy), .data_in(data_in), .p(p), .irq(irq), .nmi(nmi),
      .state(state), .ucode_in(ucode_in), .opcode(opcode), .op_word(op_word),
      .controls(controls), .op_flags(op_flags), .sync(sync), .int_ack(int_ack),
      .int_kind(int_kind), .halted(halted)
   );

   localparam int F_STATE = 0, F_SYNC = 1, F_KIND = 2, F_ACK = 3,
                  F_CTRL = 4, F_OPC = 5, F_FLAGS = 6, F_HALT = 7;

   typedef struct {
      int          cyc;
      int          fld;
      logic [63:0] want;
      string       name;
   } chk_t;

   chk_t sbq[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge ph2) cyc <= cyc + 1;

   function automatic logic [63:0] actual(input int f);
      case (f)
         F_STATE: return 64'(state);
         F_SYNC:  return 64'(sync);
         F_KIND:  return 64'(int_kind);
         F_ACK:   return 64'(int_ack);
         F_CTRL:  return 64'(controls);
         F_OPC:   return 64'(opcode);
         F_FLAGS: return 64'(op_flags);
         default: return 64'(halted);
      endcase
   endfunction

   always @(negedge ph2) begin
      chk_t        e;
      logic [63:0] act;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e   = sbq.pop_front();
         act = actual(e.fld);
         checks++;
         if (e.cyc != cyc || act !== e.want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.name, act, e.want, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge ph2);
      #1;
   endtask

   task automatic want(input string n, input int f, input logic [63:0] v);
      chk_t e;
      e.cyc = cyc; e.fld = f; e.want = v; e.name = n;
      sbq.push_back(e);
   endtask

   function automatic logic [48:0] mku(input int s, input logic last, input logic osel,
                                       input logic [1:0] nsel, input logic [7:0] nxt);
      logic [22:0] cs;
      logic [13:0] cos;
      cs  = 23'h40000 | 23'(s);
      cos = 14'h1000 | 14'(s);
      return {cs, cos, last, osel, nsel, nxt};
   endfunction

   function automatic logic [30:0] mko(input int o, input logic pol, input logic [7:0] flags,
                                       input logic [7:0] disp);
      logic [13:0] coo;
      coo = 14'h2000 | 14'(o);
      return {coo, pol, flags, disp};
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) begin
         urom[i] = mku(i, 1'b0, 1'b0, 2'b00, 8'd0);
         orom[i] = mko(i, 1'b0, 8'h00, 8'd0);
      end
      urom[0]  = mku(0,  1'b0, 1'b1, 2'b01, 8'd0);
      urom[62] = mku(62, 1'b0, 1'b0, 2'b00, 8'd5);
      urom[5]  = mku(5,  1'b1, 1'b0, 2'b00, 8'd0);
      urom[3]  = mku(3,  1'b0, 1'b0, 2'b00, 8'd9);
      urom[9]  = mku(9,  1'b0, 1'b0, 2'b00, 8'd10);
      urom[10] = mku(10, 1'b1, 1'b0, 2'b00, 8'd0);
      urom[63] = mku(63, 1'b1, 1'b0, 2'b00, 8'd0);
      urom[64] = mku(64, 1'b1, 1'b0, 2'b00, 8'd0);
      urom[20] = mku(20, 1'b0, 1'b0, 2'b10, 8'd0);
      urom[60] = mku(60, 1'b1, 1'b0, 2'b00, 8'd0);
      urom[30] = mku(30, 1'b1, 1'b0, 2'b11, 8'd0);
      orom[8'h69] = mko(8'h69, 1'b0, 8'h02, 8'd3);
      orom[8'h20] = mko(8'h20, 1'b0, 8'h02, 8'd20);
      orom[8'h30] = mko(8'h30, 1'b0, 8'h00, 8'd30);

      reset = 1'b1; rdy = 1'b1; irq = 1'b0; nmi = 1'b0; data_in = 8'h00; p = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      want("rst_state", F_STATE, 64'd62);
      want("rst_kind",  F_KIND,  64'd3);
      want("rst_ack",   F_ACK,   64'd1);
      want("rst_sync",  F_SYNC,  64'd0);
      want("rst_halt",  F_HALT,  64'd0);
      tick();
      want("seq_state", F_STATE, 64'd5);
      want("ack_once",  F_ACK,   64'd0);
      want("kind_hold", F_KIND,  64'd3);
      tick();
      data_in = 8'h69;
      want("fetch_state", F_STATE, 64'd0);
      want("fetch_sync",  F_SYNC,  64'd1);
      want("fetch_kind",  F_KIND,  64'd0);
      want("fetch_opc",   F_OPC,   64'h69);
      want("fetch_ctrl",  F_CTRL,  64'({23'h40000, 14'h2069}));
      tick();
      data_in = 8'h00;
      want("disp_state", F_STATE, 64'd3);
      want("disp_opc",   F_OPC,   64'h69);
      want("disp_sync",  F_SYNC,  64'd0);
      tick();
      rdy = 1'b0;
      want("s9_state", F_STATE, 64'd9);
      want("s9_ctrl",  F_CTRL,  64'({23'h40009, 14'h1009}));
      tick();
      nmi = 1'b1;
      want("stall1", F_STATE, 64'd9);
      tick();
      nmi = 1'b0;
      want("stall2", F_STATE, 64'd9);
      want("stall2_ctrl", F_CTRL, 64'({23'h40009, 14'h1009}));
      tick();
      rdy = 1'b1; irq = 1'b1; p = 8'h00;
      want("stall3", F_STATE, 64'd9);
      tick();
      want("resume_state", F_STATE, 64'd10);
      tick();
      want("nmi_state", F_STATE, 64'd63);
      want("nmi_kind",  F_KIND,  64'd2);
      want("nmi_ack",   F_ACK,   64'd1);
      want("nmi_sync",  F_SYNC,  64'd0);
      tick();
      p = 8'h06;
      want("irq_state", F_STATE, 64'd64);
      want("irq_kind",  F_KIND,  64'd1);
      want("irq_ack",   F_ACK,   64'd1);
      tick();
      data_in = 8'h20;
      want("mask_state", F_STATE, 64'd0);
      want("mask_sync",  F_SYNC,  64'd1);
      want("mask_kind",  F_KIND,  64'd0);
      want("mask_ack",   F_ACK,   64'd0);
      tick();
      data_in = 8'h00;
      want("br_disp",  F_STATE, 64'd20);
      want("br_flags", F_FLAGS, 64'h02);
      tick();
      want("br_taken", F_STATE, 64'd60);
      tick();
      data_in = 8'h30; p = 8'h04;
      want("mask2_state", F_STATE, 64'd0);
      want("mask2_sync",  F_SYNC,  64'd1);
      tick();
      data_in = 8'h00;
      want("s30_state", F_STATE, 64'd30);
      want("s30_ctrl",  F_CTRL,  64'({23'h4001E, 14'h101E}));
      tick();
`ifdef UCODE_HALT_EN
      nmi = 1'b1;
      want("halt_set",   F_HALT,  64'd1);
      want("halt_state", F_STATE, 64'd30);
      want("halt_ctrl",  F_CTRL,  64'd0);
      want("halt_sync",  F_SYNC,  64'd0);
      tick();
      nmi = 1'b0;
      want("halt_nmi_state", F_STATE, 64'd30);
      tick();
      want("halt_hold_state", F_STATE, 64'd30);
      want("halt_hold", F_HALT, 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      want("halt_clr",     F_HALT,  64'd0);
      want("halt_clr_st",  F_STATE, 64'd62);
      want("halt_clr_kind", F_KIND, 64'd3);
`else
      data_in = 8'h20;
      want("ns11_state", F_STATE, 64'd0);
      want("ns11_sync",  F_SYNC,  64'd1);
      want("ns11_halt",  F_HALT,  64'd0);
      tick();
      data_in = 8'h00;
      want("br2_disp", F_STATE, 64'd20);
      tick();
      want("br_not_taken", F_STATE, 64'd0);
      want("bnt_sync",     F_SYNC,  64'd0);
`endif
      tick();
      tick();
      if (sbq.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
         errors += sbq.size();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
